// File: rtl/game_ctrl_if.sv
// Signal bundle between game_ctrl (master) and the front end / sprite blocks (slave).
// Widths follow the obstacle channel count and the number of BCD score digits.
interface game_ctrl_if #(
   parameter int NUM_OBJ      = 3,
   parameter int SCORE_DIGITS = 4
);
   logic                      start_i;
   logic                      pause_i;
   logic                      frame_i;
   logic                      visible_i;
   logic [15:0]               rand_i;
   logic                      player_px_i;
   logic [NUM_OBJ-1:0]        obj_px_i;
   logic [NUM_OBJ-1:0]        obj_busy_i;
   logic [2:0]                state_o;
   logic                      frame_en_o;
   logic                      obj_rst_o;
   logic [NUM_OBJ-1:0]        spawn_o;
   logic [4*SCORE_DIGITS-1:0] score_o;
   logic [4*SCORE_DIGITS-1:0] hiscore_o;
   logic [2:0]                lives_o;
   logic [2:0]                level_o;
   logic                      blink_o;

   modport master (
      input  start_i, pause_i, frame_i, visible_i, rand_i, player_px_i, obj_px_i, obj_busy_i,
      output state_o, frame_en_o, obj_rst_o, spawn_o, score_o, hiscore_o, lives_o, level_o, blink_o
   );

   modport slave (
      output start_i, pause_i, frame_i, visible_i, rand_i, player_px_i, obj_px_i, obj_busy_i,
      input  state_o, frame_en_o, obj_rst_o, spawn_o, score_o, hiscore_o, lives_o, level_o, blink_o
   );
endinterface

// File: rtl/game_ctrl.sv
// Dino-run game-flow controller: lives, invulnerability, pause, saturating BCD score,
// high score, speed levels and gap-limited round-robin obstacle spawning.
module game_ctrl #(
   parameter int NUM_OBJ       = 3,
   parameter int LIVES         = 3,
   parameter int SCORE_DIGITS  = 4,
   parameter int INVULN_FRAMES = 60,
   parameter int LEVEL_FRAMES  = 600,
   parameter int SPAWN_GAP     = 48
) (
   input logic         clk_i,
   input logic         rst_i,
   game_ctrl_if.master bus
);
   localparam int SW = 4 * SCORE_DIGITS;
   localparam int PW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_HIT   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   state_t             state_q, state_d, ret_q, ret_d, hit_next_s;
   logic               coll_q, coll_d;
   logic [7:0]         inv_q, inv_d;
   logic [2:0]         lives_q, lives_d;
   logic [2:0]         level_q, level_d;
   logic [11:0]        lvl_cnt_q, lvl_cnt_d;
   logic [7:0]         gap_q, gap_d;
   logic [PW-1:0]      rr_q, rr_d;
   logic [NUM_OBJ-1:0] spawn_q, spawn_d;
   logic [SW-1:0]      score_q, score_d;
   logic [SW-1:0]      hiscore_q, hiscore_d;
   logic               obj_rst_q, obj_rst_d;
   logic               blink_q, blink_d;

   logic               frame_en_s, coll_now_s, coll_hit_s, hit_frame_s, new_game_s;
   logic [8:0]         gap_thr_s;
   logic               rnd_ok_s;
   logic               found_s;
   logic [PW-1:0]      win_s;
   logic [PW:0]        sum_s;

   // Saturating BCD +1: a carry out of the top digit means the score was all 9s.
   function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
      logic [SW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      for (int d = 0; d < SCORE_DIGITS; d++) begin
         if (carry && (v[4*d +: 4] == 4'd9)) begin
            r[4*d +: 4] = 4'd0;
         end else if (carry) begin
            r[4*d +: 4] = v[4*d +: 4] + 4'd1;
            carry       = 1'b0;
         end else begin
            r[4*d +: 4] = v[4*d +: 4];
         end
      end
      return carry ? v : r;
   endfunction

   assign frame_en_s  = bus.frame_i && ((state_q == ST_RUN) || (state_q == ST_HIT));
   assign coll_now_s  = (state_q == ST_RUN) && bus.visible_i && bus.player_px_i && (|bus.obj_px_i);
   assign coll_hit_s  = coll_q || coll_now_s;
   assign hit_frame_s = (state_q == ST_RUN) && bus.frame_i && coll_hit_s;
   assign gap_thr_s   = 9'(SPAWN_GAP) - {4'd0, level_q, 2'b00};
   assign rnd_ok_s    = ({1'b0, bus.rand_i[3:0]} < (5'd4 + {2'b00, level_q}));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         ret_q   <= ST_RUN;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
      end
   end

   // A collision on a frame outranks a same-cycle pause, which is then dropped.
   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      new_game_s = 1'b0;
      hit_next_s = (bus.frame_i && (inv_q <= 8'd1)) ? ST_RUN : ST_HIT;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (bus.start_i) begin
               state_d    = ST_RUN;
               new_game_s = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (hit_frame_s) begin
               state_d = (lives_q <= 3'd1) ? ST_OVER : ST_HIT;
            end else if (bus.pause_i) begin
               state_d = ST_PAUSE;
               ret_d   = ST_RUN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HIT: begin
            if (bus.pause_i) begin
               state_d = ST_PAUSE;
               ret_d   = hit_next_s;
            end else begin
               state_d = hit_next_s;
            end
         end
         ST_PAUSE: begin
            if (bus.pause_i) begin
               state_d = ret_q;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      score_d   = score_q;
      hiscore_d = hiscore_q;
      lives_d   = lives_q;
      level_d   = level_q;
      lvl_cnt_d = lvl_cnt_q;
      inv_d     = inv_q;
      gap_d     = gap_q;
      rr_d      = rr_q;
      spawn_d   = '0;
      found_s   = 1'b0;
      win_s     = '0;
      sum_s     = '0;

      if (new_game_s) begin
         score_d   = '0;
         lives_d   = 3'(LIVES);
         level_d   = 3'd0;
         lvl_cnt_d = 12'd0;
         gap_d     = 8'd0;
      end else if (frame_en_s) begin
         if (hit_frame_s) begin
            lives_d = lives_q - 3'd1;
            inv_d   = 8'(INVULN_FRAMES);
         end else if (state_q == ST_HIT) begin
            score_d = bcd_inc(score_q);
            inv_d   = inv_q - 8'd1;
         end else begin
            score_d = bcd_inc(score_q);
         end

         if (lvl_cnt_q >= 12'(LEVEL_FRAMES - 1)) begin
            lvl_cnt_d = 12'd0;
            level_d   = (level_q == 3'd7) ? level_q : level_q + 3'd1;
         end else begin
            lvl_cnt_d = lvl_cnt_q + 12'd1;
         end

         // Round-robin search for the first idle channel starting at the pointer.
         if (({1'b0, gap_q} >= gap_thr_s) && rnd_ok_s) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
               sum_s = {1'b0, rr_q} + (PW+1)'(i);
               if (sum_s >= (PW+1)'(NUM_OBJ)) begin
                  sum_s = sum_s - (PW+1)'(NUM_OBJ);
               end else begin
                  sum_s = sum_s;
               end
               if (!found_s && !bus.obj_busy_i[sum_s[PW-1:0]]) begin
                  found_s = 1'b1;
                  win_s   = sum_s[PW-1:0];
               end else begin
                  found_s = found_s;
               end
            end
            if (found_s) begin
               spawn_d[win_s] = 1'b1;
               gap_d          = 8'd0;
               rr_d           = (win_s == PW'(NUM_OBJ - 1)) ? '0 : win_s + PW'(1);
            end else begin
               gap_d = gap_q;
            end
         end else begin
            gap_d = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;
         end
      end else begin
         score_d = score_q;
      end

      // Score is frozen in OVER, so a running max there equals an on-entry compare.
      if ((state_q == ST_OVER) && (score_q > hiscore_q)) begin
         hiscore_d = score_q;
      end else begin
         hiscore_d = hiscore_q;
      end

      if ((state_q == ST_RUN) && !bus.frame_i) begin
         coll_d = coll_q || coll_now_s;
      end else begin
         coll_d = 1'b0;
      end

      obj_rst_d = new_game_s || (state_d == ST_IDLE);
      blink_d   = (state_d == ST_HIT) ? inv_d[3] : 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         coll_q    <= 1'b0;
         inv_q     <= 8'd0;
         lives_q   <= 3'd0;
         level_q   <= 3'd0;
         lvl_cnt_q <= 12'd0;
         gap_q     <= 8'd0;
         rr_q      <= '0;
         spawn_q   <= '0;
         score_q   <= '0;
         hiscore_q <= '0;
         obj_rst_q <= 1'b1;
         blink_q   <= 1'b0;
      end else begin
         coll_q    <= coll_d;
         inv_q     <= inv_d;
         lives_q   <= lives_d;
         level_q   <= level_d;
         lvl_cnt_q <= lvl_cnt_d;
         gap_q     <= gap_d;
         rr_q      <= rr_d;
         spawn_q   <= spawn_d;
         score_q   <= score_d;
         hiscore_q <= hiscore_d;
         obj_rst_q <= obj_rst_d;
         blink_q   <= blink_d;
      end
   end

   assign bus.state_o    = state_q;
   assign bus.frame_en_o = frame_en_s;
   assign bus.obj_rst_o  = obj_rst_q;
   assign bus.spawn_o    = spawn_q;
   assign bus.score_o    = score_q;
   assign bus.hiscore_o  = hiscore_q;
   assign bus.lives_o    = lives_q;
   assign bus.level_o    = level_q;
   assign bus.blink_o    = blink_q;
endmodule
